// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM arbiter: FSM states, owner encoding
// and grant-vector bit positions.
package sram_arb_pkg;

  localparam int unsigned DEF_ACCESS_CYCLES = 3;
  localparam int unsigned DEF_AW            = 21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_CPU = 2'd1,
    OWN_LDR = 2'd2
  } owner_t;

  // Bit positions in the request/grant/mask vectors, aligned with owner_t.
  localparam int unsigned IDX_VID = 0;
  localparam int unsigned IDX_CPU = 1;
  localparam int unsigned IDX_LDR = 2;

  // last_grant value meaning "loader was granted last", so the CPU wins next.
  localparam logic LG_LDR = 1'b1;

  function automatic logic [2:0] owner_onehot(input owner_t own);
    logic [2:0] v;
    v = '0;
    case (own)
      OWN_VID: v[IDX_VID] = 1'b1;
      OWN_CPU: v[IDX_CPU] = 1'b1;
      OWN_LDR: v[IDX_LDR] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational requester selection: video first, then CPU/loader round-robin.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  input  logic       last_grant,
  output logic [2:0] grant
);

  logic [2:0] eff;

  always_comb begin
    eff   = req & ~mask;
    grant = '0;
    if (eff[IDX_VID]) begin
      grant[IDX_VID] = 1'b1;
    end else if (eff[IDX_CPU] && eff[IDX_LDR]) begin
      if (last_grant == LG_LDR) grant[IDX_CPU] = 1'b1;
      else                      grant[IDX_LDR] = 1'b1;
    end else if (eff[IDX_CPU]) begin
      grant[IDX_CPU] = 1'b1;
    end else if (eff[IDX_LDR]) begin
      grant[IDX_LDR] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port arbiter for an async 8-bit SRAM: video reads, CPU read/write,
// loader writes; one access at a time through IDLE/SETUP/ACTIVE/HOLD.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int unsigned AW            = DEF_AW
) (
  input  logic          clk_chipset,
  input  logic          reset,

  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [7:0]    vid_rdata,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,

  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_addr,
  input  logic [7:0]    ldr_wdata,
  output logic          ldr_ack,

  output logic [AW-1:0] SRAM_ADDR,
  output logic          SRAM_WE_n,
  output logic [7:0]    sram_dout,
  output logic          sram_oe,
  input  logic [7:0]    sram_din
);

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  state_t        state;
  owner_t        owner;
  logic          cur_we;
  logic [3:0]    cnt;
  logic          last_grant;

  logic [2:0]    req_vec;
  logic [2:0]    mask;
  logic [2:0]    grant;

  owner_t        nxt_owner;
  logic          nxt_we;
  logic [AW-1:0] nxt_addr;
  logic [7:0]    nxt_wdata;

  assign req_vec = {ldr_req, cpu_req, vid_req};

  // The requester being acked in HOLD still has req high; keep it out.
  always_comb begin
    mask = '0;
    if (state == ST_HOLD) mask = owner_onehot(owner);
  end

  sram_arb_pick u_pick (
    .req        (req_vec),
    .mask       (mask),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    nxt_owner = OWN_VID;
    nxt_we    = 1'b0;
    nxt_addr  = vid_addr;
    nxt_wdata = '0;
    if (grant[IDX_CPU]) begin
      nxt_owner = OWN_CPU;
      nxt_we    = cpu_we;
      nxt_addr  = cpu_addr;
      nxt_wdata = cpu_wdata;
    end else if (grant[IDX_LDR]) begin
      nxt_owner = OWN_LDR;
      nxt_we    = 1'b1;
      nxt_addr  = ldr_addr;
      nxt_wdata = ldr_wdata;
    end
  end

  always_ff @(posedge clk_chipset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_VID;
      cur_we     <= 1'b0;
      cnt        <= '0;
      last_grant <= LG_LDR;
      SRAM_ADDR  <= '0;
      SRAM_WE_n  <= 1'b1;
      sram_oe    <= 1'b0;
      sram_dout  <= '0;
      vid_rdata  <= '0;
      cpu_rdata  <= '0;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      case (state)
        ST_IDLE, ST_HOLD: begin
          SRAM_WE_n <= 1'b1;
          if (|grant) begin
            state     <= ST_SETUP;
            owner     <= nxt_owner;
            cur_we    <= nxt_we;
            SRAM_ADDR <= nxt_addr;
            sram_oe   <= nxt_we;
            sram_dout <= nxt_wdata;
            if (!grant[IDX_VID]) last_grant <= grant[IDX_LDR];
          end else begin
            state   <= ST_IDLE;
            sram_oe <= 1'b0;
          end
        end
        ST_SETUP: begin
          state     <= ST_ACTIVE;
          cnt       <= '0;
          SRAM_WE_n <= ~cur_we;
        end
        ST_ACTIVE: begin
          if (cnt == LAST_CNT) begin
            state     <= ST_HOLD;
            SRAM_WE_n <= 1'b1;
            if (!cur_we) begin
              if (owner == OWN_VID) vid_rdata <= sram_din;
              if (owner == OWN_CPU) cpu_rdata <= sram_din;
            end
            vid_ack <= (owner == OWN_VID);
            cpu_ack <= (owner == OWN_CPU);
            ldr_ack <= (owner == OWN_LDR);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 3: SRAM active-phase length in clk_chipset cycles; legal range 1..15.
REQ-002 Parameter AW, default 21: SRAM address width (2 MB).
REQ-003 clk_chipset  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 vid_req  in  1  video read request; held high until vid_ack.
REQ-006 vid_addr  in  AW  video read address.
REQ-007 vid_ack  out  1  one-cycle pulse; vid_rdata valid in the same cycle.
REQ-008 cpu_req  in  1  CPU request; held high until cpu_ack.
REQ-009 cpu_we  in  1  1 = write, 0 = read.
REQ-010 cpu_addr / cpu_wdata  in  AW / 8  CPU address and write data.
REQ-011 cpu_ack  out  1  one-cycle pulse; cpu_rdata valid in the same cycle for reads.
REQ-012 ldr_req  in  1  loader write request (ROM/image load); held high until ldr_ack.
REQ-013 ldr_addr / ldr_wdata  in  AW / 8  loader address and data; the loader only writes.
REQ-014 ldr_ack  out  1  one-cycle pulse.
REQ-015 vid_rdata / cpu_rdata  out  8 / 8  registered read data.
REQ-016 SRAM_ADDR  out  AW  registered SRAM address.
REQ-017 SRAM_WE_n  out  1  registered active-low write enable.
REQ-018 sram_dout / sram_oe  out  8 / 1  write data and pad-drive enable; the top level builds the SRAM_DATA tristate from these.
REQ-019 sram_din  in  8  SRAM_DATA pad input.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, ACTIVE and HOLD.
REQ-021 Arbitration SHALL occur only in IDLE and HOLD. Video has absolute priority. CPU and loader SHALL alternate round-robin through a last_grant bit that toggles only when one of them is granted.
REQ-022 In HOLD, the requester being acked SHALL be masked from arbitration so it cannot be re-granted.
REQ-023 On a grant, the arbiter SHALL register owner, address, we and wdata, then go to SETUP on the next edge; with no grant it goes to (or stays in) IDLE.
REQ-024 SETUP lasts 1 cycle: SRAM_ADDR is driven, SRAM_WE_n=1, and sram_oe=we.
REQ-025 ACTIVE lasts exactly ACCESS_CYCLES cycles, counted by a 4-bit counter. SRAM_WE_n=0 throughout for writes and 1 for reads.
REQ-026 For reads, sram_din SHALL be captured into the owner's rdata register on the last ACTIVE cycle; the other requester's rdata is unchanged.
REQ-027 HOLD lasts 1 cycle: SRAM_WE_n=1, and address and sram_oe hold their ACTIVE values (data hold time).
REQ-028 The owner's ack SHALL be high during HOLD only.
REQ-029 Latency from a req sampled in IDLE to ack is ACCESS_CYCLES+2 cycles. Back-to-back grants SHALL go HOLD→SETUP with no idle cycle.
REQ-030 Once granted, an access SHALL run to completion regardless of req changes; dropping req before ack is a requester protocol violation and is not checked.
REQ-031 At most one ack SHALL be high in any cycle. SRAM_WE_n SHALL never be low while sram_oe=0. SRAM_ADDR SHALL be stable from SETUP through HOLD.
REQ-032 When all three requesters assert in the same cycle, grant order SHALL be video, then the CPU/loader round-robin winner.

Reset
REQ-033 While reset is high, on each edge: state=IDLE, SRAM_WE_n=1, sram_oe=0, all acks=0, SRAM_ADDR=0, sram_dout=0, rdata registers=0, counter=0, last_grant=loader (so the CPU wins first).
REQ-034 Reset asserted mid-access SHALL abort the access with no ack, and SRAM_WE_n SHALL be 1 on the edge where reset is sampled.

Structure
REQ-035 A shared package sram_arb_pkg SHALL hold the state enumeration, the owner encoding (VID, CPU, LDR) and the default ACCESS_CYCLES/AW constants.
REQ-036 One sub-module, sram_arb_pick, SHALL be natural: combinational priority/round-robin selection taking the request vector, the HOLD owner mask and last_grant, and producing a one-hot grant.

Verification
REQ-037 CPU read of 0x1ABCD with sram_din model = 0x5A, ACCESS_CYCLES=3 -> cpu_ack 5 cycles after req sampled, cpu_rdata=0x5A, SRAM_WE_n high throughout.
REQ-038 CPU write 0x0FFFF←0xC3 -> SRAM_WE_n low exactly 3 cycles, sram_oe high SETUP..HOLD, SRAM_ADDR=0x0FFFF, sram_dout=0xC3 stable.
REQ-039 vid/cpu/ldr all request in the same cycle, held until acked -> ack order vid, cpu, ldr; consecutive accesses 5 cycles apart with no idle cycle.
REQ-040 cpu_req and ldr_req held continuously, requester re-asserting after each ack -> strict alternation cpu, ldr, cpu, ldr…; no double ack.
REQ-041 Reset pulsed in the 2nd ACTIVE cycle of a write -> SRAM_WE_n=1 and sram_oe=0 on the next edge, no ack; after reset release, a pending ldr_req completes normally.
REQ-042 ACCESS_CYCLES=1 build, random traffic -> protocol assertions of REQ-031 hold and scoreboard read data matches the memory model.
